controle_multiciclo: RTL and testbench

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_multiciclo_pkg.sv | 41 ++++
 rtl/controle_multiciclo.sv | 132 +++++++++++++
 tb/tb_controle_multiciclo.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle control: state codes, opcodes and datapath mux/ALU selects.
package controle_multiciclo_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        WB_R   = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        WB_LW  = 4'd6,
        MEM_WR = 4'd7,
        BRANCH = 4'd8,
        EXEC_I = 4'd9,
        WB_I   = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } estado_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ADDI  = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/controle_multiciclo.sv
// Multicycle processor control FSM: state register plus combinational control decode.
module controle_multiciclo
    import controle_multiciclo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] estado,
    output logic       illegal
);

    estado_t state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_R:          state <= EXEC_R;
                        OP_LW, OP_SW:  state <= ADDR;
                        OP_BEQ:        state <= BRANCH;
                        OP_ADDI:       state <= EXEC_I;
                        OP_JMP:        state <= JUMP;
                        default:       state <= TRAP;
                    endcase
                end
                EXEC_R: state <= WB_R;
                WB_R:   state <= FETCH;
                ADDR:   state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD: if (mem_ready) state <= WB_LW;
                WB_LW:  state <= FETCH;
                MEM_WR: if (mem_ready) state <= FETCH;
                BRANCH: state <= FETCH;
                EXEC_I: state <= WB_I;
                WB_I:   state <= FETCH;
                JUMP:   state <= FETCH;
                TRAP:   state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    assign estado = state;

    // Controls are gated by reset so nothing reaches the datapath while it is held.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_source  = PCSRC_ALU;
        illegal    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_ONE;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = SRCB_BOFF;
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                WB_R: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                MEM_RD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                WB_LW: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_source = PCSRC_OUT;
                    pc_write  = zero;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADDI;
                end
                WB_I: reg_write = 1'b1;
                JUMP: begin
                    pc_source = PCSRC_JUMP;
                    pc_write  = 1'b1;
                end
                TRAP: illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: per-cycle state and control-vector checks.
module tb_controle_multiciclo;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] estado;

    int n_chk = 0;
    int n_pass = 0;
    int rw_cnt = 0;
    int pw_cnt = 0;
    int m2r_cnt = 0;

    always #5 clock = ~clock;

    controle_multiciclo dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .estado(estado), .illegal(illegal)
    );

    // {pw, irw, iord, mr, mw, m2r, rdst, rw, asa, asb[2], aop[2], psrc[2], ill}
    logic [15:0] ctrl;
    assign ctrl = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
                   reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

    localparam logic [15:0] C_FETCH  = 16'b1_1_0_1_0_0_0_0_0_01_00_00_0;
    localparam logic [15:0] C_FWAIT  = 16'b0_0_0_1_0_0_0_0_0_01_00_00_0;
    localparam logic [15:0] C_DECODE = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [15:0] C_EXEC_R = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [15:0] C_WB_R   = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [15:0] C_ADDR   = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [15:0] C_MEM_RD = 16'b0_0_1_1_0_0_0_0_0_00_00_00_0;
    localparam logic [15:0] C_WB_LW  = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [15:0] C_MEM_WR = 16'b0_0_1_0_1_0_0_0_0_00_00_00_0;
    localparam logic [15:0] C_BR_T   = 16'b1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [15:0] C_BR_N   = 16'b0_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [15:0] C_EXEC_I = 16'b0_0_0_0_0_0_0_0_1_10_11_00_0;
    localparam logic [15:0] C_WB_I   = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [15:0] C_JUMP   = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [15:0] C_TRAP   = 16'b0_0_0_0_0_0_0_0_0_00_00_00_1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called just after a rising edge; checks the cycle at the falling edge.
    task automatic step(input string tag, input logic [3:0] st, input logic [15:0] c);
        @(negedge clock);
        chk({tag, ".estado"}, {12'd0, estado}, {12'd0, st});
        chk({tag, ".ctrl"}, ctrl, c);
        if (reg_write) rw_cnt++;
        if (pc_write) pw_cnt++;
        if (reg_write && mem_to_reg) m2r_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, ".rst_estado"}, {12'd0, estado}, 16'd0);
        chk({tag, ".rst_ctrl"}, ctrl, 16'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; opcode = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        #3;
        chk("por.estado", {12'd0, estado}, 16'd0);
        chk("por.ctrl", ctrl, 16'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // R-type, mem_ready=1: 4 cycles
        rw_cnt = 0; pw_cnt = 0;
        step("r.c1", 4'd0, C_FETCH);
        step("r.c2", 4'd1, C_DECODE);
        step("r.c3", 4'd2, C_EXEC_R);
        step("r.c4", 4'd3, C_WB_R);
        chk("r.rw_cnt", 16'(rw_cnt), 16'd1);
        chk("r.pw_cnt", 16'(pw_cnt), 16'd1);

        // lw with two wait cycles in MEM_RD: 7 cycles
        opcode = 3'b001; rw_cnt = 0; m2r_cnt = 0;
        step("lw.c1", 4'd0, C_FETCH);
        step("lw.c2", 4'd1, C_DECODE);
        step("lw.c3", 4'd4, C_ADDR);
        mem_ready = 1'b0;
        step("lw.c4", 4'd5, C_MEM_RD);
        step("lw.c5", 4'd5, C_MEM_RD);
        mem_ready = 1'b1;
        step("lw.c6", 4'd5, C_MEM_RD);
        step("lw.c7", 4'd6, C_WB_LW);
        chk("lw.rw_cnt", 16'(rw_cnt), 16'd1);
        chk("lw.m2r_cnt", 16'(m2r_cnt), 16'd1);

        // sw with a fetch stall first
        opcode = 3'b010; mem_ready = 1'b0;
        step("sw.fwait", 4'd0, C_FWAIT);
        mem_ready = 1'b1;
        step("sw.c1", 4'd0, C_FETCH);
        step("sw.c2", 4'd1, C_DECODE);
        step("sw.c3", 4'd4, C_ADDR);
        step("sw.c4", 4'd7, C_MEM_WR);

        // beq taken then not taken
        opcode = 3'b011; zero = 1'b1;
        step("beqt.c1", 4'd0, C_FETCH);
        step("beqt.c2", 4'd1, C_DECODE);
        step("beqt.c3", 4'd8, C_BR_T);
        zero = 1'b0;
        step("beqn.c1", 4'd0, C_FETCH);
        step("beqn.c2", 4'd1, C_DECODE);
        step("beqn.c3", 4'd8, C_BR_N);

        // addi and jmp
        opcode = 3'b100;
        step("addi.c1", 4'd0, C_FETCH);
        step("addi.c2", 4'd1, C_DECODE);
        step("addi.c3", 4'd9, C_EXEC_I);
        step("addi.c4", 4'd10, C_WB_I);
        opcode = 3'b111;
        step("jmp.c1", 4'd0, C_FETCH);
        step("jmp.c2", 4'd1, C_DECODE);
        step("jmp.c3", 4'd11, C_JUMP);

        // opcode 110 traps and holds
        opcode = 3'b110;
        step("op6.c1", 4'd0, C_FETCH);
        step("op6.c2", 4'd1, C_DECODE);
        for (int i = 0; i < 10; i++) step("op6.trap", 4'd12, C_TRAP);
        do_reset("op6");
        opcode = 3'b000;
        step("op6.refetch", 4'd0, C_FETCH);
        step("op6.dec", 4'd1, C_DECODE);
        step("op6.exr", 4'd2, C_EXEC_R);
        step("op6.wbr", 4'd3, C_WB_R);

        // opcode 101 traps as well
        opcode = 3'b101;
        step("op5.c1", 4'd0, C_FETCH);
        step("op5.c2", 4'd1, C_DECODE);
        step("op5.trap", 4'd12, C_TRAP);
        do_reset("op5");

        // reset while MEM_WR is waiting on memory
        opcode = 3'b010;
        step("swr.c1", 4'd0, C_FETCH);
        step("swr.c2", 4'd1, C_DECODE);
        step("swr.c3", 4'd4, C_ADDR);
        mem_ready = 1'b0;
        step("swr.c4", 4'd7, C_MEM_WR);
        #2;
        chk("swr.pre_mw", {15'd0, mem_write}, 16'd1);
        do_reset("swr");
        chk("swr.mw_after", {15'd0, mem_write}, 16'd0);
        mem_ready = 1'b1;
        step("swr.refetch", 4'd0, C_FETCH);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
